// File: rtl/aemb2_iche_line_if.sv
// aemb2_iche_line_if: instruction Wishbone bus between the line cache
// (master) and instruction memory (slave).
interface aemb2_iche_line_if #(
    parameter int AW = 30
) ();
    logic [AW-1:0] iwb_adr_o;
    logic          iwb_stb_o;
    logic          iwb_cyc_o;
    logic [31:0]   iwb_dat_i;
    logic          iwb_ack_i;

    modport master (
        output iwb_adr_o, iwb_stb_o, iwb_cyc_o,
        input  iwb_dat_i, iwb_ack_i
    );

    modport slave (
        input  iwb_adr_o, iwb_stb_o, iwb_cyc_o,
        output iwb_dat_i, iwb_ack_i
    );
endinterface

// File: rtl/aemb2_iche_line.sv
// aemb2_iche_line: direct-mapped multi-word-line instruction cache with
// an in-order burst-fill Wishbone master and global invalidate.
module aemb2_iche_line #(
    parameter int AEMB_IWB = 32,
    parameter int AEMB_ICH = 11,
    parameter int AEMB_ILW = 2
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic                iena,
    input  logic [AEMB_IWB-3:0] ich_adr,
    input  logic                ich_inv,
    output logic [31:0]         ich_dat,
    output logic                ich_hit,
    output logic                ich_busy,
    aemb2_iche_line_if.master   iwb
);
    localparam int AW    = AEMB_IWB - 2;
    localparam int WA    = AEMB_ICH - 2;
    localparam int TW    = AEMB_IWB - AEMB_ICH;
    localparam int IW    = WA - AEMB_ILW;
    localparam int CW    = AEMB_ILW + 1;
    localparam int LW    = 1 << AEMB_ILW;
    localparam int WORDS = 1 << WA;
    localparam int LINES = 1 << IW;

    localparam logic [AW-1:0] OMASK = AW'(LW - 1);
    localparam logic [WA-1:0] WMASK = WA'(LW - 1);
    localparam logic [CW-1:0] CLAST = CW'(LW - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    state_t state;
    state_t state_d;

    logic [AW-1:0]    adr_r;
    logic [AW-1:0]    base;
    logic             rvld;
    logic             inv_pend;
    logic [CW-1:0]    cnt;
    logic [LINES-1:0] valid;
    logic [31:0]      dram [WORDS];
    logic [TW-1:0]    tram [LINES];
    logic [TW-1:0]    tag_rd;

    logic [TW-1:0] tag_r;
    logic [IW-1:0] idx_r;
    logic          is_idle;
    logic          ack_ok;
    logic          last;
    logic          fill_go;
    logic          adr_en;
    logic [WA-1:0] raddr;
    logic [WA-1:0] waddr;

    assign tag_r   = adr_r[AW-1:WA];
    assign idx_r   = adr_r[WA-1:AEMB_ILW];
    assign is_idle = (state == IDLE);
    assign ack_ok  = (state == FILL) && iwb.iwb_ack_i;
    assign last    = (cnt == CLAST);

    assign ich_hit = is_idle && rvld && valid[idx_r]
                     && (tag_rd == tag_r);
    assign fill_go = is_idle && rvld && !ich_hit && !ich_inv;
    assign ich_busy = !is_idle || inv_pend;

    // The lookup register stays frozen while a miss is being started
    assign adr_en = is_idle && iena && !fill_go;
    assign raddr  = adr_en ? ich_adr[WA-1:0] : adr_r[WA-1:0];
    assign waddr  = (adr_r[WA-1:0] & ~WMASK) | (WA'(cnt) & WMASK);

    always_ff @(posedge gclk) begin
        if (grst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d       = state;
        iwb.iwb_cyc_o = 1'b0;
        iwb.iwb_stb_o = 1'b0;
        iwb.iwb_adr_o = '0;
        unique case (state)
            IDLE: begin
                if (fill_go) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                iwb.iwb_cyc_o = 1'b1;
                iwb.iwb_stb_o = 1'b1;
                iwb.iwb_adr_o = base | AW'(cnt);
                if (ack_ok && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            adr_r    <= '0;
            base     <= '0;
            rvld     <= 1'b0;
            cnt      <= '0;
            inv_pend <= 1'b0;
            valid    <= '0;
        end else begin
            if (adr_en) begin
                adr_r <= ich_adr;
                rvld  <= 1'b1;
            end
            if (fill_go) begin
                base <= adr_r & ~OMASK;
                cnt  <= '0;
            end else if (ack_ok) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end
            // Pending invalidate only lives across FILL/DONE
            inv_pend <= (state == FILL) && (inv_pend || ich_inv);
            if (is_idle && ich_inv) begin
                valid <= '0;
            end else if ((state == DONE) && (inv_pend || ich_inv)) begin
                valid <= '0;
            end else if (ack_ok && last && !inv_pend && !ich_inv) begin
                valid[idx_r] <= 1'b1;
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (ack_ok) begin
            dram[waddr] <= iwb.iwb_dat_i;
        end
        ich_dat <= dram[raddr];
    end

    always_ff @(posedge gclk) begin
        if (ack_ok && last) begin
            tram[idx_r] <= tag_r;
        end
        tag_rd <= tram[raddr[WA-1:AEMB_ILW]];
    end
endmodule

// File: tb/tb_aemb2_iche_line.sv
// tb_aemb2_iche_line: randomized lookups against a line-level cache model
// with a wait-state Wishbone memory slave.
module tb_aemb2_iche_line;
    localparam int IWB   = 32;
    localparam int ICH   = 11;
    localparam int ILW   = 2;
    localparam int AW    = IWB - 2;
    localparam int LW    = 1 << ILW;
    localparam int WPL   = 1 << (ICH - 2);
    localparam int LINES = WPL / LW;

    logic          clk;
    logic          grst;
    logic          iena;
    logic [AW-1:0] ich_adr;
    logic          ich_inv;
    logic [31:0]   ich_dat;
    logic          ich_hit;
    logic          ich_busy;

    aemb2_iche_line_if #(.AW(AW)) wb ();

    aemb2_iche_line #(
        .AEMB_IWB(IWB),
        .AEMB_ICH(ICH),
        .AEMB_ILW(ILW)
    ) dut (
        .gclk    (clk),
        .grst    (grst),
        .iena    (iena),
        .ich_adr (ich_adr),
        .ich_inv (ich_inv),
        .ich_dat (ich_dat),
        .ich_hit (ich_hit),
        .ich_busy(ich_busy),
        .iwb     (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit            m_vld [LINES];
    int            m_tag [LINES];
    logic [AW-1:0] cur_addr = '0;
    logic [AW-1:0] exp_q [$];
    int            wq [$];

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem(input logic [AW-1:0] a);
        return 32'(a) * 32'h9E37_79B9 + 32'h0000_1357;
    endfunction

    function automatic int line_of(input logic [AW-1:0] a);
        return (int'(a) / LW) % LINES;
    endfunction

    function automatic int tag_of(input logic [AW-1:0] a);
        return int'(a) / WPL;
    endfunction

    function automatic bit model_hit(input logic [AW-1:0] a);
        return m_vld[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
    endfunction

    function automatic void model_fill(input logic [AW-1:0] a);
        m_vld[line_of(a)] = 1'b1;
        m_tag[line_of(a)] = tag_of(a);
    endfunction

    function automatic int wait_of(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 2;
        return int'($urandom_range(0, 3));
    endfunction

    // Queue the bus words and wait states of one line fill; returns the
    // number of cycles from miss detection to the hit being visible.
    task automatic push_fill(input logic [AW-1:0] a, input int mode,
                             output int len);
        logic [AW-1:0] b;
        int w;
        b = AW'((int'(a) / LW) * LW);
        len = 2;
        for (int i = 0; i < LW; i++) begin
            exp_q.push_back(b + AW'(i));
            w = wait_of(mode);
            wq.push_back(w);
            len += w + 1;
        end
    endtask

    function automatic bit busy_at(input int lat, input int l1,
                                   input int tot, input bit dbl);
        if (lat >= 1 && lat <= l1 - 1) return 1'b1;
        if (dbl && lat >= l1 + 1 && lat <= tot - 1) return 1'b1;
        return 1'b0;
    endfunction

    // Memory slave and cycle-by-cycle bus/data checks
    logic [AW-1:0] prev_adr = '0;
    bit            prev_stb = 1'b0;
    bit            sl_loaded = 1'b0;
    int            wleft = 0;

    always @(negedge clk) begin
        logic [AW-1:0] e;
        chk(wb.iwb_cyc_o == wb.iwb_stb_o, "cyc_eq_stb",
            64'(wb.iwb_cyc_o), 64'(wb.iwb_stb_o));
        if (wb.iwb_stb_o) begin
            chk(ich_busy, "busy_in_fill", 64'(ich_busy), 64'd1);
        end
        if (wb.iwb_stb_o && prev_stb && !wb.iwb_ack_i) begin
            chk(wb.iwb_adr_o == prev_adr, "adr_hold",
                64'(wb.iwb_adr_o), 64'(prev_adr));
        end
        if (ich_hit) begin
            chk(ich_dat == mem(cur_addr), "hit_data",
                64'(ich_dat), 64'(mem(cur_addr)));
        end
        prev_stb = wb.iwb_stb_o;
        prev_adr = wb.iwb_adr_o;
        if (wb.iwb_stb_o) begin
            if (!sl_loaded) begin
                wleft = (wq.size() > 0) ? wq.pop_front() : 0;
                sl_loaded = 1'b1;
            end
            if (wleft == 0) begin
                wb.iwb_ack_i = 1'b1;
                wb.iwb_dat_i = mem(wb.iwb_adr_o);
                sl_loaded = 1'b0;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_fill",
                        64'(wb.iwb_adr_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(wb.iwb_adr_o == e, "fill_adr",
                        64'(wb.iwb_adr_o), 64'(e));
                end
            end else begin
                wb.iwb_ack_i = 1'b0;
                wb.iwb_dat_i = $urandom;
                wleft--;
            end
        end else begin
            wb.iwb_ack_i = ($urandom_range(0, 3) == 0);
            wb.iwb_dat_i = $urandom;
            sl_loaded = 1'b0;
        end
    end

    // Starting at the negedge after the triggering edge, follow the DUT
    // until the hit appears; optionally pulse ich_inv at cycle inv_k.
    task automatic follow(input int l1, input int tot, input bit dbl,
                          input int inv_k, output int lat);
        lat = 0;
        forever begin
            chk(ich_busy == busy_at(lat, l1, tot, dbl), "busy",
                64'(ich_busy), 64'(busy_at(lat, l1, tot, dbl)));
            if (inv_k > 0 && lat == inv_k) ich_inv = 1'b1;
            if (inv_k > 0 && lat == inv_k + 1) ich_inv = 1'b0;
            if (ich_hit || lat >= tot + 20) break;
            @(negedge clk);
            lat++;
        end
        ich_inv = 1'b0;
        chk(lat == tot, "latency", 64'(lat), 64'(tot));
        chk(ich_hit, "final_hit", 64'(ich_hit), 64'd1);
    endtask

    task automatic lookup(input logic [AW-1:0] a, input int mode,
                          input int inv_k, output int lat);
        bit h;
        bit dbl;
        int l1;
        int l2;
        int k;
        h = model_hit(a);
        dbl = 1'b0;
        l1 = 0;
        l2 = 0;
        k = -1;
        if (!h) begin
            push_fill(a, mode, l1);
            if (inv_k >= 0) begin
                dbl = 1'b1;
                push_fill(a, mode, l2);
                k = (inv_k == 0) ? int'($urandom_range(1, l1 - 1)) : inv_k;
            end
        end
        @(posedge clk);
        #1;
        ich_adr = a;
        iena = 1'b1;
        @(posedge clk);
        #1;
        iena = 1'b0;
        cur_addr = a;
        @(negedge clk);
        follow(l1, l1 + l2, dbl, k, lat);
        chk(ich_dat == mem(a), "lookup_data", 64'(ich_dat), 64'(mem(a)));
        if (dbl) model_clear();
        if (!h) model_fill(a);
    endtask

    task automatic inv_idle(input int mode, output int lat);
        int len;
        model_clear();
        push_fill(cur_addr, mode, len);
        @(posedge clk);
        #1;
        ich_inv = 1'b1;
        @(posedge clk);
        #1;
        ich_inv = 1'b0;
        @(negedge clk);
        chk(!ich_hit, "inv_idle_hit0", 64'(ich_hit), 64'd0);
        follow(len, len, 1'b0, -1, lat);
        model_fill(cur_addr);
    endtask

    task automatic hits_b2b(input logic [AW-1:0] a0, input int n);
        @(posedge clk);
        #1;
        ich_adr = a0;
        iena = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cur_addr = a0 + AW'(i);
            if (i < n - 1) ich_adr = a0 + AW'(i + 1);
            else iena = 1'b0;
            @(negedge clk);
            chk(ich_hit == model_hit(cur_addr), "b2b_hit",
                64'(ich_hit), 64'(model_hit(cur_addr)));
            chk(!wb.iwb_cyc_o, "b2b_no_bus", 64'(wb.iwb_cyc_o), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int r;
        logic [AW-1:0] a;
        model_clear();
        grst = 1'b1;
        iena = 1'b0;
        ich_inv = 1'b0;
        ich_adr = '0;
        repeat (3) @(posedge clk);
        #1;
        grst = 1'b0;
        @(negedge clk);
        chk(!ich_hit, "rst_hit", 64'(ich_hit), 64'd0);
        chk(!ich_busy, "rst_busy", 64'(ich_busy), 64'd0);
        chk(!wb.iwb_stb_o, "rst_stb", 64'(wb.iwb_stb_o), 64'd0);
        chk(wb.iwb_adr_o == '0, "rst_adr", 64'(wb.iwb_adr_o), 64'd0);

        // Reset in the middle of a burst
        push_fill(30'h400, 0, lat);
        @(posedge clk);
        #1;
        ich_adr = 30'h400;
        iena = 1'b1;
        @(posedge clk);
        #1;
        iena = 1'b0;
        cur_addr = 30'h400;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(wb.iwb_adr_o == 30'h402, "mid_burst_adr",
            64'(wb.iwb_adr_o), 64'h402);
        chk(wb.iwb_stb_o, "mid_burst_stb", 64'(wb.iwb_stb_o), 64'd1);
        @(posedge clk);
        #1;
        grst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        grst = 1'b0;
        exp_q.delete();
        wq.delete();
        model_clear();
        @(negedge clk);
        chk(!wb.iwb_cyc_o, "rst2_cyc", 64'(wb.iwb_cyc_o), 64'd0);
        chk(!ich_hit, "rst2_hit", 64'(ich_hit), 64'd0);
        chk(!ich_busy, "rst2_busy", 64'(ich_busy), 64'd0);

        lookup(30'h400, 0, -1, lat);
        chk(lat == 6, "cold_lat", 64'(lat), 64'd6);
        hits_b2b(30'h401, 3);
        lookup(30'h600, 0, -1, lat);
        chk(lat == 6, "conflict_lat", 64'(lat), 64'd6);
        lookup(30'h400, 0, -1, lat);
        chk(lat == 6, "conflict_back_lat", 64'(lat), 64'd6);
        lookup(30'h800, 1, -1, lat);
        chk(lat == 14, "wait_lat", 64'(lat), 64'd14);
        hits_b2b(30'h800, 4);
        inv_idle(0, lat);
        chk(lat == 6, "inv_idle_lat", 64'(lat), 64'd6);
        lookup(30'hA04, 1, 3, lat);
        chk(lat == 28, "inv_fill_lat", 64'(lat), 64'd28);
        lookup(30'h800, 0, -1, lat);
        chk(lat == 6, "after_inv_miss", 64'(lat), 64'd6);

        for (int it = 0; it < 60; it++) begin
            a = AW'($urandom_range(2, 5) * WPL
                   + $urandom_range(0, 3) * LW
                   + $urandom_range(0, LW - 1));
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                inv_idle(int'($urandom_range(0, 2)), lat);
            end else if (r == 1) begin
                lookup(a, int'($urandom_range(0, 2)), 0, lat);
            end else if (r == 2) begin
                hits_b2b(AW'((int'(cur_addr) / LW) * LW), LW);
            end else begin
                lookup(a, int'($urandom_range(0, 2)), -1, lat);
            end
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
